// File: rtl/fp_add_align.sv
// fp_add_align: two-stage operand alignment for the floating-point adder.
//   Stage 1 orders the operands by magnitude and registers the exponent
//   difference; stage 2 right-shifts the smaller significand, folding the
//   shifted-out bits into a sticky bit in bit 0.
// Latency: 2 register stages (capture edge, then output edge); one op/cycle.
// Backpressure: valid/ready; stage 2 loads when empty or out_ready=1,
//   stage 1 loads when empty or draining into stage 2; outputs hold while
//   out_valid=1 and out_ready=0.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       input handshake
//   sub, aSign, bSign         opcode (1 = a-b) and operand signs
//   aExp, bExp                signed unbiased exponents (NEXP+2 bits)
//   aSig, bSig                normalized significands (NSIG+1 bits)
//   aFlags, bFlags            class flags (one-hot by flag index)
//   out_valid / out_ready     output handshake
//   out_sign, out_effSub      result sign of larger operand, effective subtract
//   out_exp, out_lSig, out_sSig, out_swap, out_special, out_aFlags, out_bFlags
module fp_add_align #(
  parameter int NEXP     = 5,
  parameter int NSIG     = 10,
  parameter int NTYPES   = 6,
  parameter int SNAN     = 5,
  parameter int QNAN     = 4,
  parameter int INFINITY = 3,
  parameter int ZERO     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sub,
  input  logic                   aSign,
  input  logic                   bSign,
  input  logic signed [NEXP+1:0] aExp,
  input  logic signed [NEXP+1:0] bExp,
  input  logic [NSIG:0]          aSig,
  input  logic [NSIG:0]          bSig,
  input  logic [NTYPES-1:0]      aFlags,
  input  logic [NTYPES-1:0]      bFlags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic                   out_effSub,
  output logic signed [NEXP+1:0] out_exp,
  output logic [NSIG+3:0]        out_lSig,
  output logic [NSIG+3:0]        out_sSig,
  output logic                   out_swap,
  output logic                   out_special,
  output logic [NTYPES-1:0]      out_aFlags,
  output logic [NTYPES-1:0]      out_bFlags
);

  localparam int NX = NSIG + 4;
  localparam int NE = NEXP + 2;

  // ---------------- handshake ----------------
  logic s1_vld_q, s2_vld_q;
  logic s1_load, s2_load;

  assign s2_load  = ~s2_vld_q | out_ready;
  assign s1_load  = ~s1_vld_q | s2_load;
  assign in_ready = s1_load;

  // ---------------- stage 1: compare / swap ----------------
  logic                 s1_sign_d,    s1_sign_q;
  logic                 s1_effsub_d,  s1_effsub_q;
  logic signed [NE-1:0] s1_exp_d,     s1_exp_q;
  logic [NSIG:0]        s1_lsig_d,    s1_lsig_q;
  logic [NSIG:0]        s1_ssig_d,    s1_ssig_q;
  logic [NE-1:0]        s1_diff_d,    s1_diff_q;
  logic                 s1_swap_d,    s1_swap_q;
  logic                 s1_special_d, s1_special_q;
  logic [NTYPES-1:0]    s1_aflags_d,  s1_aflags_q;
  logic [NTYPES-1:0]    s1_bflags_d,  s1_bflags_q;

  logic                 a_zero, b_zero;
  logic signed [NE-1:0] small_exp;

  always_comb begin
    a_zero = aFlags[ZERO];
    b_zero = bFlags[ZERO];

    // A zero operand never wins the magnitude race; otherwise exponent
    // decides, then significand. Ties leave a as the larger operand.
    if (b_zero)            s1_swap_d = 1'b0;
    else if (a_zero)       s1_swap_d = 1'b1;
    else if (bExp > aExp)  s1_swap_d = 1'b1;
    else if (bExp == aExp) s1_swap_d = (bSig > aSig);
    else                   s1_swap_d = 1'b0;

    s1_exp_d  = s1_swap_d ? bExp : aExp;
    small_exp = s1_swap_d ? aExp : bExp;
    s1_lsig_d = s1_swap_d ? bSig : aSig;
    s1_ssig_d = s1_swap_d ? aSig : bSig;

    // Zero operands carry an arbitrary exponent; their significand is 0,
    // so a zero shift keeps the sticky logic from seeing anything.
    if (a_zero | b_zero) s1_diff_d = '0;
    else                 s1_diff_d = NE'(s1_exp_d - small_exp);

    s1_sign_d    = s1_swap_d ? (bSign ^ sub) : aSign;
    s1_effsub_d  = aSign ^ bSign ^ sub;
    s1_special_d = aFlags[SNAN] | aFlags[QNAN] | aFlags[INFINITY] |
                   bFlags[SNAN] | bFlags[QNAN] | bFlags[INFINITY];
    s1_aflags_d  = aFlags;
    s1_bflags_d  = bFlags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_effsub_q  <= 1'b0;
      s1_exp_q     <= '0;
      s1_lsig_q    <= '0;
      s1_ssig_q    <= '0;
      s1_diff_q    <= '0;
      s1_swap_q    <= 1'b0;
      s1_special_q <= 1'b0;
      s1_aflags_q  <= '0;
      s1_bflags_q  <= '0;
    end else if (s1_load) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_sign_q    <= s1_sign_d;
        s1_effsub_q  <= s1_effsub_d;
        s1_exp_q     <= s1_exp_d;
        s1_lsig_q    <= s1_lsig_d;
        s1_ssig_q    <= s1_ssig_d;
        s1_diff_q    <= s1_diff_d;
        s1_swap_q    <= s1_swap_d;
        s1_special_q <= s1_special_d;
        s1_aflags_q  <= s1_aflags_d;
        s1_bflags_q  <= s1_bflags_d;
      end
    end
  end

  // ---------------- stage 2: align ----------------
  logic                 s2_sign_q, s2_effsub_q, s2_swap_q, s2_special_q;
  logic signed [NE-1:0] s2_exp_d, s2_exp_q;
  logic [NX-1:0]        s2_lsig_d, s2_lsig_q;
  logic [NX-1:0]        s2_ssig_d, s2_ssig_q;
  logic                 s2_swap_d;
  logic [NTYPES-1:0]    s2_aflags_q, s2_bflags_q;

  logic [NX-1:0] ext, shifted, lost_mask, aligned;
  logic          lost;

  always_comb begin
    ext       = {s1_ssig_q, 3'b000};
    shifted   = ext >> s1_diff_q;
    lost_mask = ~({NX{1'b1}} << s1_diff_q);
    lost      = |(ext & lost_mask);
    // Shifting by NX or more leaves only the sticky bit.
    if (s1_diff_q >= NE'(NX)) aligned = {{(NX-1){1'b0}}, |s1_ssig_q};
    else                      aligned = shifted | {{(NX-1){1'b0}}, lost};

    // Specials bypass the add datapath; zero its operands.
    if (s1_special_q) begin
      s2_exp_d  = '0;
      s2_lsig_d = '0;
      s2_ssig_d = '0;
      s2_swap_d = 1'b0;
    end else begin
      s2_exp_d  = s1_exp_q;
      s2_lsig_d = {s1_lsig_q, 3'b000};
      s2_ssig_d = aligned;
      s2_swap_d = s1_swap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q     <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_effsub_q  <= 1'b0;
      s2_exp_q     <= '0;
      s2_lsig_q    <= '0;
      s2_ssig_q    <= '0;
      s2_swap_q    <= 1'b0;
      s2_special_q <= 1'b0;
      s2_aflags_q  <= '0;
      s2_bflags_q  <= '0;
    end else if (s2_load) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_sign_q    <= s1_sign_q;
        s2_effsub_q  <= s1_effsub_q;
        s2_exp_q     <= s2_exp_d;
        s2_lsig_q    <= s2_lsig_d;
        s2_ssig_q    <= s2_ssig_d;
        s2_swap_q    <= s2_swap_d;
        s2_special_q <= s1_special_q;
        s2_aflags_q  <= s1_aflags_q;
        s2_bflags_q  <= s1_bflags_q;
      end
    end
  end

  assign out_valid   = s2_vld_q;
  assign out_sign    = s2_sign_q;
  assign out_effSub  = s2_effsub_q;
  assign out_exp     = s2_exp_q;
  assign out_lSig    = s2_lsig_q;
  assign out_sSig    = s2_ssig_q;
  assign out_swap    = s2_swap_q;
  assign out_special = s2_special_q;
  assign out_aFlags  = s2_aflags_q;
  assign out_bFlags  = s2_bflags_q;

endmodule

// File: tb/tb_fp_add_align.sv
// Testbench for fp_add_align (half precision): directed vectors with
// hand-computed results, scoreboard queue filled at acceptance and drained
// by an independent output monitor.
module tb_fp_add_align;

  localparam logic [5:0] FN = 6'b000001;  // NORMAL
  localparam logic [5:0] FZ = 6'b000100;  // ZERO
  localparam logic [5:0] FI = 6'b001000;  // INFINITY

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic sub = 1'b0, aSign = 1'b0, bSign = 1'b0;
  logic signed [6:0] aExp = '0, bExp = '0;
  logic [10:0] aSig = '0, bSig = '0;
  logic [5:0]  aFlags = '0, bFlags = '0;
  logic out_valid, out_ready = 1'b1;
  logic out_sign, out_effSub, out_swap, out_special;
  logic signed [6:0] out_exp;
  logic [13:0] out_lSig, out_sSig;
  logic [5:0]  out_aFlags, out_bFlags;

  always #5 clk = ~clk;

  fp_add_align dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .aSign(aSign), .bSign(bSign), .aExp(aExp), .bExp(bExp),
    .aSig(aSig), .bSig(bSig), .aFlags(aFlags), .bFlags(bFlags),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_effSub(out_effSub), .out_exp(out_exp), .out_lSig(out_lSig),
    .out_sSig(out_sSig), .out_swap(out_swap), .out_special(out_special),
    .out_aFlags(out_aFlags), .out_bFlags(out_bFlags)
  );

  typedef struct {
    logic sub, as, bs;
    logic [6:0] ae, be;
    logic [10:0] asg, bsg;
    logic [5:0] af, bf;
    logic [50:0] exp;   // {sign, effSub, exp, lSig, sSig, swap, special, aFlags, bFlags}
  } vec_t;

  int n_cmp = 0, n_bad = 0, acc = 0;
  logic [50:0] sb[$];

  function automatic vec_t mk(logic s, logic as_, logic bs_, int ae, int be,
                              logic [10:0] asg, logic [10:0] bsg, logic [5:0] af, logic [5:0] bf,
                              logic es, logic ee, int eexp, logic [13:0] el, logic [13:0] es2,
                              logic esw, logic esp);
    vec_t v;
    v.sub = s; v.as = as_; v.bs = bs_;
    v.ae = 7'(ae); v.be = 7'(be); v.asg = asg; v.bsg = bsg; v.af = af; v.bf = bf;
    v.exp = {es, ee, 7'(eexp), el, es2, esw, esp, af, bf};
    return v;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic logic [50:0] dut_out();
    return {out_sign, out_effSub, out_exp, out_lSig, out_sSig, out_swap, out_special, out_aFlags, out_bFlags};
  endfunction

  // Called just after a rising edge; returns just after the capture edge.
  task automatic send(vec_t v);
    bit done = 0;
    sub = v.sub; aSign = v.as; bSign = v.bs; aExp = v.ae; bExp = v.be;
    aSig = v.asg; bSig = v.bsg; aFlags = v.af; bFlags = v.bf;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(v.exp);
        acc++;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  // Monitor: every transfer on the output is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_output", 64'(dut_out()), 64'(0));
      else check("result", 64'(dut_out()), 64'(sb.pop_front()));
    end
  end

  vec_t v[10];
  bit bp_done;

  initial begin
    v[0] = mk(0,0,0,   0,  -1, 11'h400, 11'h400, FN, FN, 0,0,  0, 14'h2000, 14'h1000, 0, 0);
    v[1] = mk(1,0,0,  -3,   2, 11'h500, 11'h400, FN, FN, 1,1,  2, 14'h2000, 14'h0140, 1, 0);
    v[2] = mk(0,0,0,   0, -12, 11'h400, 11'h401, FN, FN, 0,0,  0, 14'h2000, 14'h0003, 0, 0);
    v[3] = mk(0,0,0,   0, -20, 11'h400, 11'h401, FN, FN, 0,0,  0, 14'h2000, 14'h0001, 0, 0);
    v[4] = mk(0,1,0,  16,   0, 11'h400, 11'h400, FI, FN, 1,1,  0, 14'h0000, 14'h0000, 0, 1);
    v[5] = mk(0,0,0, -15,  -5, 11'h000, 11'h600, FZ, FN, 0,0, -5, 14'h3000, 14'h0000, 1, 0);
    v[6] = mk(0,0,1,   3,   3, 11'h400, 11'h480, FN, FN, 1,1,  3, 14'h2400, 14'h2000, 1, 0);
    v[7] = mk(0,1,0,   1,   1, 11'h500, 11'h500, FN, FN, 1,1,  1, 14'h2800, 14'h2800, 0, 0);
    v[8] = mk(0,0,0,   0, -13, 11'h7FF, 11'h400, FN, FN, 0,0,  0, 14'h3FF8, 14'h0001, 0, 0);
    v[9] = mk(0,0,0,   0, -13, 11'h400, 11'h7FF, FN, FN, 0,0,  0, 14'h2000, 14'h0001, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_data", 64'(dut_out()), 64'(0));
    @(posedge clk); #1;

    // Latency: not visible in the cycle after capture, visible one cycle later.
    send(v[0]);
    @(negedge clk);
    check("latency_early", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("latency_due", 64'(out_valid), 64'(1));
    @(posedge clk); #1;

    // Remaining directed vectors back to back.
    for (int i = 1; i < 10; i++) send(v[i]);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: four ops against a blocked output.
    out_ready = 1'b0;
    acc = 0;
    bp_done = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(v[i]);
        bp_done = 1;
      end
    join_none
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bp_accepted", 64'(acc), 64'(2));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_hold_a", 64'(dut_out()), 64'(v[0].exp));
    @(negedge clk);
    check("bp_hold_b", 64'(dut_out()), 64'(v[0].exp));
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_stream_valid", 64'(out_valid), 64'(1));
    end
    for (int t = 0; t < 50 && !bp_done; t++) @(posedge clk);
    check("bp_driver_done", 64'(bp_done), 64'(1));
    @(posedge clk); #1;

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send(v[1]);
    send(v[2]);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'(0));
    check("rst_mid_data", 64'(dut_out()), 64'(0));
    check("rst_mid_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_stale", 64'(out_valid), 64'(0));
    end

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
